// File: rtl/argmax_stream_ctrl.sv
// Serial argmax over one frame of N_CLASSES scores using a single compare-and-select path.
// Define ARGMAX_SIGNED_EN to treat scores as two's-complement; the default build compares unsigned.
module argmax_stream_ctrl #(
  parameter int N_CLASSES = 10,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_max,
  output logic [1:0]        dbg_state
);

  // Handshakes: a beat moves on a cycle where in_valid && in_ready; the result moves on a
  // cycle where out_valid && out_ready. out_valid never drops before it is accepted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  best_idx;
  logic [DATA_W-1:0] best_val;
  logic              accept;
  logic              last_beat;
  logic              higher;
  logic              take;

  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == LAST_IDX);
  assign dbg_state = state;

`ifdef ARGMAX_SIGNED_EN
  assign higher = ($signed(in_data) > $signed(best_val));
`else
  assign higher = (in_data > best_val);
`endif

  // Strict compare keeps the earlier index on ties; beat 0 always seeds the best registers.
  assign take = (cnt == '0) || higher;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && last_beat) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
    end else if (accept && !last_beat) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_val <= '0;
      best_idx <= '0;
    end else if (accept && take) begin
      best_val <= in_data;
      best_idx <= cnt;
    end
  end

  // Result registers capture the final winner on the last beat, so they stay put while the
  // next frame is loading and only change when a new result is ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_idx <= '0;
      out_max <= '0;
    end else if (accept && last_beat) begin
      out_idx <= take ? cnt : best_idx;
      out_max <= take ? in_data : best_val;
    end
  end

endmodule

// File: tb/tb_argmax_stream_ctrl.sv
// Bench for argmax_stream_ctrl: directed and random frames, reference argmax model, result scoreboard.
// Compile with ARGMAX_SIGNED_EN defined to check the signed build.
module tb_argmax_stream_ctrl;

  localparam int N = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_idx;
  logic [7:0] out_max;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;

  logic [11:0] exp_q[$];
  logic [7:0]  sc  [N];
  int          gap [N];

  argmax_stream_ctrl #(.N_CLASSES(N), .DATA_W(8), .IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_max   (out_max),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first position holding the largest value, under the build's number interpretation.
  function automatic logic [11:0] model();
    int best;
    int v;
    logic [3:0] idx;
    logic [7:0] mx;
    best = -1000;
    idx  = '0;
    mx   = '0;
    for (int i = 0; i < N; i++) begin
`ifdef ARGMAX_SIGNED_EN
      v = int'($signed(sc[i]));
`else
      v = int'(sc[i]);
`endif
      if (v > best) begin
        best = v;
        idx  = 4'(i);
        mx   = sc[i];
      end
    end
    return {idx, mx};
  endfunction

  // scoreboard monitor: result must match the queue head every cycle it is presented
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got idx %0d max %0h expected none", out_idx, out_max);
      end else begin
        check("out_idx", 32'(out_idx), 32'(exp_q[0][11:8]));
        check("out_max", 32'(out_max), 32'(exp_q[0][7:0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // driver: start, beats with optional bubbles, then result handshake after `hold` stall cycles
  task automatic run_frame(input int hold, input bit start_in_done);
    exp_q.push_back(model());
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int b = 0; b < gap[i]; b++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
        check("in_ready_bubble", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = sc[i];
      @(negedge clk);
      check("in_ready_beat", 32'(in_ready), 32'd1);
      check("out_valid_early", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = start_in_done;
      @(negedge clk);
      check("out_valid_held", 32'(out_valid), 32'd1);
      check("busy_done", 32'(busy), 32'd1);
      check("in_ready_done", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    out_ready = 1'b1;
    start = start_in_done;
    @(negedge clk);
    check("out_valid_hs", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("out_valid_after", 32'(out_valid), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd0);
  endtask

  task automatic clear_gaps();
    for (int i = 0; i < N; i++) gap[i] = 0;
  endtask

  initial begin
    int waited;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    clear_gaps();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_out_idx", 32'(out_idx), 32'd0);
      check("idle_out_max", 32'(out_max), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    sc = '{8'd3, 8'd17, 8'd9, 8'd200, 8'd4, 8'd0, 8'd55, 8'd199, 8'd1, 8'd12};
    run_frame(0, 1'b0);

    sc = '{8'd50, 8'd90, 8'd90, 8'd10, 8'd90, 8'd0, 8'd0, 8'd0, 8'd0, 8'd90};
    gap[5] = 2;
    run_frame(0, 1'b0);
    clear_gaps();

    for (int i = 0; i < N; i++) sc[i] = 8'($urandom_range(1, 255));
    run_frame(5, 1'b1);

    // abort a frame with reset after six beats
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(1, 255));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_max", 32'(out_max), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    sc = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5};
    run_frame(0, 1'b0);

    sc = '{8'h7F, 8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_frame(1, 1'b0);
    sc = '{8'h10, 8'hF0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_frame(0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < N; i++) begin
        sc[i]  = (f % 2 == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
        gap[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      end
      run_frame(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    clear_gaps();

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
